rsv_scb_requester: RTL and testbench

- Reservation-station-side initiator of the stable-scoreboard request protocol (search_pip / available / req).
- Buffers dispatched instructions in an in-order queue and presents the head's target execution pipe to the scoreboard.
- Issues the head to its pipe only when the scoreboard reports available, pulsing req so the scoreboard tracks the issued destination.
- Sits between the dispatch stage and the stable execution pipes of one reservation station.

---
 rtl/rsv_scb_requester.sv | 105 ++++++++++
 tb/tb_rsv_scb_requester.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rsv_scb_requester.sv
// rsv_scb_requester: in-order reservation-station queue that issues its head to a stable
// execution pipe through the scoreboard search_pip / available / req handshake.
module rsv_scb_requester #(
    parameter logic [2:0] RSV_ID  = 3'b0,
    parameter int         DEPTH   = 4,
    parameter int         PIP_W   = 3,
    parameter int         PREG_W  = 6,
    parameter int         PAY_W   = 32,
    parameter int         STALL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PIP_W-1:0]           disp_pipe,
    input  logic [PREG_W-1:0]          disp_preg_rd,
    input  logic [PAY_W-1:0]           disp_payload,
    output logic [PIP_W-1:0]           scb_search_pip,
    input  logic                       scb_available,
    output logic                       scb_req,
    output logic                       iss_valid,
    output logic [PIP_W-1:0]           iss_pipe,
    output logic [PREG_W-1:0]          iss_preg_rd,
    output logic [PAY_W-1:0]           iss_payload,
    output logic [2:0]                 iss_rsv_id,
    output logic [STALL_W-1:0]         stall_cnt,
    output logic [$clog2(DEPTH):0]     q_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PIP_W + PREG_W + PAY_W;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_QUERY = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               iss_valid_q, iss_valid_d;
    logic [PIP_W-1:0]   iss_pipe_q, iss_pipe_d;
    logic [PREG_W-1:0]  iss_preg_q, iss_preg_d;
    logic [PAY_W-1:0]   iss_pay_q, iss_pay_d;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      head_e;
    logic               push, query;

    assign query          = state_q == S_QUERY;
    assign head_e         = mem_q[head_q];
    assign disp_ready     = (count_q != CW'(DEPTH)) && !flush;
    assign push           = disp_valid && disp_ready;
    assign scb_req        = query && scb_available && !flush;
    assign scb_search_pip = query ? head_e[EW-1 -: PIP_W] : '0;

    always_comb begin
        count_d     = flush ? '0 : count_q + CW'(push) - CW'(scb_req);
        head_d      = flush ? '0 : head_q + AW'(scb_req);
        tail_d      = flush ? '0 : tail_q + AW'(push);
        state_d     = flush ? S_FLUSH : (state_q == S_FLUSH) ? S_IDLE : (count_d != '0) ? S_QUERY : S_IDLE;
        iss_valid_d = scb_req;
        iss_pipe_d  = scb_req ? head_e[EW-1 -: PIP_W] : iss_pipe_q;
        iss_preg_d  = scb_req ? head_e[PREG_W+PAY_W-1 -: PREG_W] : iss_preg_q;
        iss_pay_d   = scb_req ? head_e[PAY_W-1:0] : iss_pay_q;
        stall_d     = (query && !scb_available && !flush && stall_q != '1) ? stall_q + STALL_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            stall_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_pipe_q  <= '0;
            iss_preg_q  <= '0;
            iss_pay_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            stall_q     <= stall_d;
            iss_valid_q <= iss_valid_d;
            iss_pipe_q  <= iss_pipe_d;
            iss_preg_q  <= iss_preg_d;
            iss_pay_q   <= iss_pay_d;
        end
    end

    // Entry storage is unreset; occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[tail_q] <= {disp_pipe, disp_preg_rd, disp_payload};
    end

    assign iss_valid   = iss_valid_q;
    assign iss_pipe    = iss_pipe_q;
    assign iss_preg_rd = iss_preg_q;
    assign iss_payload = iss_pay_q;
    assign iss_rsv_id  = RSV_ID;
    assign stall_cnt   = stall_q;
    assign q_count     = count_q;
endmodule

// File: tb/tb_rsv_scb_requester.sv
// tb_rsv_scb_requester: directed stimulus with a queue-based reference model checked every cycle.
module tb_rsv_scb_requester;
    logic        clk = 0, rst_n = 0, flush = 0, disp_valid = 0, scb_available = 0;
    logic [2:0]  disp_pipe = 0;
    logic [5:0]  disp_preg_rd = 0;
    logic [31:0] disp_payload = 0;
    logic        disp_ready, scb_req, iss_valid;
    logic [2:0]  scb_search_pip, iss_pipe, iss_rsv_id;
    logic [5:0]  iss_preg_rd;
    logic [31:0] iss_payload;
    logic [3:0]  stall_cnt;
    logic [2:0]  q_count;

    rsv_scb_requester #(.RSV_ID(3'd5), .DEPTH(4), .PIP_W(3), .PREG_W(6), .PAY_W(32), .STALL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pipe(disp_pipe),
        .disp_preg_rd(disp_preg_rd), .disp_payload(disp_payload),
        .scb_search_pip(scb_search_pip), .scb_available(scb_available), .scb_req(scb_req),
        .iss_valid(iss_valid), .iss_pipe(iss_pipe), .iss_preg_rd(iss_preg_rd),
        .iss_payload(iss_payload), .iss_rsv_id(iss_rsv_id), .stall_cnt(stall_cnt), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [2:0] p; logic [5:0] r; logic [31:0] d;} ent_t;
    ent_t        mq[$];
    ent_t        hd;
    int          errors = 0, checks = 0, iss_seen = 0;
    logic        m_query, m_req, m_rdy, e_iv = 0;
    logic [2:0]  e_ip = 0;
    logic [5:0]  e_ir = 0;
    logic [31:0] e_id = 0;
    logic [3:0]  e_st = 0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Reference: the queue is live whenever it holds entries; flush empties it after its cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            e_iv = 0; e_ip = 0; e_ir = 0; e_id = 0; e_st = 0;
        end
        m_query = mq.size() > 0;
        m_req   = m_query && scb_available && !flush && rst_n;
        m_rdy   = mq.size() != 4 && !flush;
        chk("disp_ready", disp_ready, m_rdy);
        chk("scb_req", scb_req, m_req);
        chk("search_pip", scb_search_pip, m_query ? mq[0].p : 3'd0);
        chk("iss_valid", iss_valid, e_iv);
        chk("iss_pipe", iss_pipe, e_ip);
        chk("iss_preg", iss_preg_rd, e_ir);
        chk("iss_payload", iss_payload, e_id);
        chk("iss_rsv_id", iss_rsv_id, 3'd5);
        chk("stall_cnt", stall_cnt, e_st);
        chk("q_count", q_count, mq.size());
        if (rst_n) begin
            if (iss_valid) iss_seen++;
            if (m_query && !scb_available && !flush && e_st != 4'hF) e_st = e_st + 1;
            e_iv = m_req;
            if (m_req) begin
                hd = mq.pop_front();
                e_ip = hd.p; e_ir = hd.r; e_id = hd.d;
            end
            if (disp_valid && m_rdy) mq.push_back('{disp_pipe, disp_preg_rd, disp_payload});
            if (flush) mq.delete();
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic put(input logic [2:0] p, input logic [5:0] r, input logic [31:0] d);
        disp_valid = 1; disp_pipe = p; disp_preg_rd = r; disp_payload = d;
    endtask

    initial begin
        logic [2:0] pipes [4];
        logic [2:0] order [4];
        int base;
        pipes = '{3'd1, 3'd3, 3'd5, 3'd7};
        order = '{3'd3, 3'd5, 3'd7, 3'd6};
        repeat (2) step();
        @(negedge clk);
        chk("rst_qcount", q_count, 0);
        chk("rst_iss_valid", iss_valid, 0);
        step(); rst_n = 1;
        // single dispatch
        step(); put(3'd2, 6'h15, 32'hDEADBEEF); scb_available = 1;
        step(); disp_valid = 0;
        @(negedge clk);
        chk("t1_req", scb_req, 1);
        chk("t1_pip", scb_search_pip, 2);
        step();
        @(negedge clk);
        chk("t1_iss_valid", iss_valid, 1);
        chk("t1_iss_pipe", iss_pipe, 2);
        chk("t1_iss_preg", iss_preg_rd, 6'h15);
        chk("t1_iss_payload", iss_payload, 32'hDEADBEEF);
        chk("t1_qcount", q_count, 0);
        // fill with scoreboard blocked
        step(); scb_available = 0;
        for (int i = 0; i < 4; i++) begin
            put(pipes[i], 6'(i + 8), 32'h1000 + i);
            step();
        end
        disp_valid = 0;
        step(); step();
        @(negedge clk);
        chk("fill_qcount", q_count, 4);
        chk("fill_ready", disp_ready, 0);
        chk("fill_req", scb_req, 0);
        chk("fill_stall", stall_cnt, 5);
        // full queue: issue and dispatch in the same cycle, dispatch refused
        step(); scb_available = 1; put(3'd6, 6'h3F, 32'h66);
        @(negedge clk);
        chk("full_ready", disp_ready, 0);
        chk("full_req", scb_req, 1);
        step(); scb_available = 0;
        @(negedge clk);
        chk("full_q3", q_count, 3);
        chk("full_ready_again", disp_ready, 1);
        step(); disp_valid = 0;
        @(negedge clk);
        chk("full_q4", q_count, 4);
        // drain back-to-back
        step(); scb_available = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) chk("drain_pipe", iss_pipe, order[i - 1]);
            chk("drain_req", scb_req, 1);
            step();
        end
        @(negedge clk);
        chk("drain_last_pipe", iss_pipe, order[3]);
        chk("drain_qcount", q_count, 0);
        // interleaved dispatch/issue across the wrap
        step(); base = iss_seen;
        for (int i = 0; i < 6; i++) begin
            put(3'(i), 6'(i), 32'd100 + i);
            scb_available = i[0];
            step();
        end
        disp_valid = 0; scb_available = 1;
        repeat (6) step();
        @(negedge clk);
        chk("wrap_issues", iss_seen - base, 6);
        chk("wrap_qcount", q_count, 0);
        // flush with three queued entries
        step(); scb_available = 0;
        for (int i = 0; i < 3; i++) begin
            put(3'(i + 1), 6'(i + 20), 32'hF0 + i);
            step();
        end
        scb_available = 1; flush = 1; put(3'd4, 6'd4, 32'h44);
        @(negedge clk);
        chk("flush_req", scb_req, 0);
        chk("flush_ready", disp_ready, 0);
        step(); flush = 0; disp_valid = 0;
        @(negedge clk);
        chk("flush_q0", q_count, 0);
        chk("flush_state_req", scb_req, 0);
        step();
        @(negedge clk);
        chk("flush_idle_req", scb_req, 0);
        // reset mid-stream
        step(); scb_available = 0;
        for (int i = 0; i < 3; i++) begin
            put(3'(i + 2), 6'(i + 30), 32'hA0 + i);
            step();
        end
        disp_valid = 0; scb_available = 1;
        step(); scb_available = 0;
        chk("prerst_iss_valid", iss_valid, 1);
        chk("prerst_qcount", q_count, 2);
        #1 rst_n = 0;
        #1;
        chk("rst_iss_valid_async", iss_valid, 0);
        chk("rst_qcount_async", q_count, 0);
        chk("rst_stall_async", stall_cnt, 0);
        step(); step(); rst_n = 1; scb_available = 1;
        @(negedge clk);
        chk("post_rst_req", scb_req, 0);
        // stall saturation
        step(); scb_available = 0; put(3'd7, 6'd1, 32'h77);
        step(); disp_valid = 0;
        repeat (20) step();
        @(negedge clk);
        chk("stall_sat", stall_cnt, 15);
        chk("stall_req", scb_req, 0);
        step(); scb_available = 1;
        repeat (3) step();
        @(negedge clk);
        chk("final_qcount", q_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
